free_list_alloc: RTL and testbench
==================================

FREE_LIST_ALLOC -- requirements
Module: free_list_alloc

Interface
REQ-001 SHALL have parameter RESERVED, default 32: tags 0..RESERVED-1 are held by architectural mappings at reset; legal range 0..63.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_alloc_ack  input  1  consumer takes the staged tag this cycle.
REQ-005 SHALL have port o_alloc_valid  output  1  staged tag present.
REQ-006 SHALL have port o_alloc_tag  output  6  staged tag; meaningful only when o_alloc_valid=1.
REQ-007 SHALL have port i_free_valid  input  1  return strobe.
REQ-008 SHALL have port i_free_tag  input  6  tag being returned.
REQ-009 SHALL have port o_free_count  output  7  tags not held by consumers: bitmap popcount plus staged tag.
REQ-010 SHALL have port o_empty  output  1  high when o_free_count==0.
REQ-011 SHALL have port o_double_free  output  1  one-cycle registered pulse on an illegal return.

Function
REQ-012 SHALL hold a 64-bit free bitmap (bit n=1: tag n free) and a one-entry staging register (valid + 6-bit tag) driving o_alloc_valid/o_alloc_tag.
REQ-013 SHALL treat the staging register as consumed when o_alloc_valid & i_alloc_ack; i_alloc_ack with o_alloc_valid=0 SHALL be ignored.
REQ-014 SHALL, each edge where the staging register is empty or being consumed and the bitmap (pre-edge value) is nonzero, load the lowest-index set bit into staging and clear that bit; index 0 has highest priority.
REQ-015 SHALL support back-to-back allocation: with ack held high and enough free tags, o_alloc_valid stays 1 and o_alloc_tag advances every cycle.
REQ-016 SHALL, when consumed and bitmap is zero, drop o_alloc_valid to 0 at that edge.
REQ-017 SHALL set bitmap bit i_free_tag at the edge where i_free_valid=1 (and the return is legal); a freed tag is selectable no earlier than the following edge, so earliest appearance on o_alloc_tag is 2 edges after the strobe.
REQ-018 SHALL, for a simultaneous free and selection in one cycle, base selection on the pre-edge bitmap and apply both the clear (selected bit) and the set (freed bit).
REQ-019 SHALL define an illegal return as i_free_tag whose bitmap bit is already 1, or equal to the staged tag while o_alloc_valid=1 and not consumed that cycle.
REQ-020 SHALL register o_free_count and o_empty from next-state values, so they reflect the bitmap and staging contents after each edge.
REQ-021 SHALL never stage a tag twice and never lose a tag: total of bitmap popcount, staged tag and tags held by consumers is invariant at 64-RESERVED+RESERVED.

Reset
REQ-022 SHALL, while i_rst_n=0, asynchronously force bitmap bits 0..RESERVED-1 to 0 and RESERVED..63 to 1, staging valid=0, o_alloc_tag=0, o_double_free=0, o_free_count=64-RESERVED, o_empty=(RESERVED==64).
REQ-023 SHALL stage tag RESERVED on the first rising edge after i_rst_n deasserts (if RESERVED<64).
REQ-024 SHALL, on reset asserted mid-operation, discard any staged tag and in-flight free; state is exactly REQ-022.

Configuration
REQ-025 SHALL honour macro FREE_LIST_CHECK_EN: when defined, illegal returns (REQ-019) pulse o_double_free the next cycle and leave the bitmap unchanged.
REQ-026 SHALL, without FREE_LIST_CHECK_EN, tie o_double_free to 0 and apply every return as an unconditional bit set; a return equal to the unconsumed staged tag sets the bit, corrupting the invariant (caller's responsibility).

Verification
REQ-027 Reset with RESERVED=32, release, ack high 32 cycles -> tags 32,33,...,63 in order, then o_alloc_valid=0, o_empty=1, o_free_count=0.
REQ-028 From empty, free tag 5 at cycle N -> o_alloc_valid=1 with tag 5 after edge N+2; o_free_count=1 after edge N+1.
REQ-029 Staged tag 40, ack and free tag 7 in same cycle -> next staged tag is 41 (pre-edge bitmap), tag 7 staged after 41 consumed before any higher index.
REQ-030 With FREE_LIST_CHECK_EN, free tag 50 while bit 50 set -> o_double_free=1 for exactly one cycle, o_free_count unchanged.
REQ-031 Assert i_rst_n=0 mid-allocation with tag 45 staged -> immediately o_alloc_valid=0, o_free_count=32; after release tag 32 staged.

Source files
------------

// File: rtl/free_list_alloc.sv
// free_list_alloc
//
// Physical-tag free list for a rename stage. A 64-bit bitmap records which
// tags are free (bit n = 1 means tag n is free). A one-entry staging register
// always holds the lowest-index free tag, ready for the consumer to take.
// Tags 0..RESERVED-1 belong to architectural mappings at reset.
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_alloc_ack    consumer takes the staged tag this cycle
//   o_alloc_valid  staged tag present
//   o_alloc_tag    staged tag (meaningful only when o_alloc_valid = 1)
//   i_free_valid   return strobe
//   i_free_tag     tag being returned
//   o_free_count   free bitmap popcount plus staged tag (registered)
//   o_empty        high when o_free_count == 0 (registered)
//   o_double_free  one-cycle registered pulse on an illegal return
//
// Configuration
//   FREE_LIST_CHECK_EN  when defined, illegal returns (tag already free, or
//                       equal to the unconsumed staged tag) are dropped and
//                       flagged on o_double_free. When undefined, every
//                       return is applied as a plain bit set and
//                       o_double_free stays 0.

module free_list_alloc #(
    parameter int RESERVED = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_alloc_ack,
    output logic       o_alloc_valid,
    output logic [5:0] o_alloc_tag,
    input  logic       i_free_valid,
    input  logic [5:0] i_free_tag,
    output logic [6:0] o_free_count,
    output logic       o_empty,
    output logic       o_double_free
);

    // Reserved tags start out held; everything above them starts free.
    // A shift by 64 yields zero, so RESERVED = 64 gives an all-zero map.
    localparam logic [63:0] RESET_MAP   = ~((64'd1 << RESERVED) - 64'd1);
    localparam logic [6:0]  RESET_COUNT = 7'(64 - RESERVED);
    localparam logic        RESET_EMPTY = (RESERVED == 64);

    logic [63:0] bitmap_q,     bitmap_d;
    logic        stageValid_q, stageValid_d;
    logic [5:0]  stageTag_q,   stageTag_d;
    logic [6:0]  freeCount_q,  freeCount_d;
    logic        empty_q,      empty_d;
    logic        doubleFree_q, doubleFree_d;

    logic        consume;
    logic        canLoad;
    logic        pickFound;
    logic [5:0]  pickTag;
    logic        illegalFree;
    logic        applyFree;
    logic [6:0]  mapCount;

    assign consume = stageValid_q & i_alloc_ack;
    assign canLoad = ~stageValid_q | consume;

    // Lowest set bit of the pre-edge bitmap; scanning downwards lets the
    // lowest index overwrite any higher one found earlier.
    always_comb begin
        pickFound = 1'b0;
        pickTag   = '0;
        for (int n = 63; n >= 0; n--) begin
            if (bitmap_q[n]) begin
                pickFound = 1'b1;
                pickTag   = 6'(n);
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    // A staged tag that is being consumed this cycle may legitimately come
    // back in the same cycle only after it left staging, so it is excluded.
    assign illegalFree = i_free_valid &
                         (bitmap_q[i_free_tag] |
                          (stageValid_q & ~consume & (stageTag_q == i_free_tag)));
`else
    assign illegalFree = 1'b0;
`endif

    assign applyFree = i_free_valid & ~illegalFree;

    // Selection clears its bit and a legal return sets its bit in the same
    // edge; the set is applied last so it is never lost.
    always_comb begin
        bitmap_d     = bitmap_q;
        stageValid_d = stageValid_q;
        stageTag_d   = stageTag_q;
        if (canLoad) begin
            stageValid_d = pickFound;
            if (pickFound) begin
                stageTag_d          = pickTag;
                bitmap_d[pickTag]   = 1'b0;
            end
        end
        if (applyFree) begin
            bitmap_d[i_free_tag] = 1'b1;
        end
        doubleFree_d = illegalFree;
    end

    // Count and empty are registered from next-state so they describe the
    // bitmap and staging contents right after each edge.
    always_comb begin
        mapCount = '0;
        for (int n = 0; n < 64; n++) begin
            mapCount = mapCount + {6'd0, bitmap_d[n]};
        end
        freeCount_d = mapCount + {6'd0, stageValid_d};
        empty_d     = (freeCount_d == 7'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bitmap_q     <= RESET_MAP;
            stageValid_q <= 1'b0;
            stageTag_q   <= '0;
            freeCount_q  <= RESET_COUNT;
            empty_q      <= RESET_EMPTY;
            doubleFree_q <= 1'b0;
        end else begin
            bitmap_q     <= bitmap_d;
            stageValid_q <= stageValid_d;
            stageTag_q   <= stageTag_d;
            freeCount_q  <= freeCount_d;
            empty_q      <= empty_d;
            doubleFree_q <= doubleFree_d;
        end
    end

    assign o_alloc_valid = stageValid_q;
    assign o_alloc_tag   = stageTag_q;
    assign o_free_count  = freeCount_q;
    assign o_empty       = empty_q;
    assign o_double_free = doubleFree_q;

endmodule

// File: tb/tb_free_list_alloc.sv
// tb_free_list_alloc
//
// Bench for free_list_alloc with the default RESERVED = 32. Allocation order
// is tracked with a queue of expected tags that is popped whenever the bench
// acknowledges a valid staged tag. A per-cycle vector table covers returns,
// simultaneous free/select and draining; hand-written sequences cover reset,
// double returns and reset in the middle of allocation.

module tb_free_list_alloc;

    logic       iClk;
    logic       iRstN;
    logic       iAllocAck;
    logic       oAllocValid;
    logic [5:0] oAllocTag;
    logic       iFreeValid;
    logic [5:0] iFreeTag;
    logic [6:0] oFreeCount;
    logic       oEmpty;
    logic       oDoubleFree;

    int vecCount  = 0;
    int missCount = 0;

    logic [5:0] expQ[$];

    typedef struct {
        logic       ack;
        logic       freeValid;
        logic [5:0] freeTag;
        logic       expValid;
        logic [5:0] expTag;
        logic [6:0] expCount;
        logic       expEmpty;
    } vec_t;

    vec_t vecs[10];

    free_list_alloc #(.RESERVED(32)) dut (
        .i_clk         (iClk),
        .i_rst_n       (iRstN),
        .i_alloc_ack   (iAllocAck),
        .o_alloc_valid (oAllocValid),
        .o_alloc_tag   (oAllocTag),
        .i_free_valid  (iFreeValid),
        .i_free_tag    (iFreeTag),
        .o_free_count  (oFreeCount),
        .o_empty       (oEmpty),
        .o_double_free (oDoubleFree)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; if the consumer takes a tag this cycle the
    // tag is compared against the head of the expected-order queue. Returns
    // 1 time unit after the rising edge so outputs are sampled off the edge.
    task automatic applyStimulus(input logic ack, input logic fv, input logic [5:0] ft);
        iAllocAck  = ack;
        iFreeValid = fv;
        iFreeTag   = ft;
        #1;
        if (ack && oAllocValid) begin
            if (expQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL allocOrder: got tag %0d, expected no allocation", oAllocTag);
            end else begin
                checkOutput("allocOrder", {58'd0, oAllocTag}, {58'd0, expQ.pop_front()});
            end
        end
        @(posedge iClk);
        #1;
        iAllocAck  = 1'b0;
        iFreeValid = 1'b0;
        iFreeTag   = '0;
    endtask

    task automatic checkQueueDrained(input string name);
        checkOutput(name, 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    initial begin
        iRstN      = 1'b1;
        iAllocAck  = 1'b0;
        iFreeValid = 1'b0;
        iFreeTag   = '0;

        // Vector table, starting from an empty free list with every tag
        // held by a consumer. Fields: ack, freeValid, freeTag, then the
        // expected valid, tag, count and empty after the edge.
        vecs[0] = '{1'b0, 1'b1, 6'd5,  1'b0, 6'd0,  7'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd5,  7'd1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 6'd40, 1'b0, 6'd0,  7'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 6'd41, 1'b1, 6'd40, 7'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 6'd7,  1'b1, 6'd41, 7'd2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 6'd42, 1'b1, 6'd41, 7'd3, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd7,  7'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd42, 7'd1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  7'd0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  7'd0, 1'b1};

        // Reset values, observed while reset is held.
        #2 iRstN = 1'b0;
        #1;
        checkOutput("resetValid",      {63'd0, oAllocValid}, 64'd0);
        checkOutput("resetTag",        {58'd0, oAllocTag},   64'd0);
        checkOutput("resetCount",      {57'd0, oFreeCount},  64'd32);
        checkOutput("resetEmpty",      {63'd0, oEmpty},      64'd0);
        checkOutput("resetDoubleFree", {63'd0, oDoubleFree}, 64'd0);
        @(posedge iClk);
        @(posedge iClk);
        #1 iRstN = 1'b1;

        // First edge after release stages tag 32; then drain 32..63.
        for (int t = 32; t < 64; t++) expQ.push_back(6'(t));
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("firstStageValid", {63'd0, oAllocValid}, 64'd1);
        checkOutput("firstStageTag",   {58'd0, oAllocTag},   64'd32);
        checkOutput("firstStageCount", {57'd0, oFreeCount},  64'd32);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, 1'b0, 6'd0);
            checkOutput("drainCount", {57'd0, oFreeCount}, 64'(32 - k));
        end
        checkOutput("drainValid", {63'd0, oAllocValid}, 64'd0);
        checkOutput("drainEmpty", {63'd0, oEmpty},      64'd1);
        checkQueueDrained("drainQueue");

        // Returns, simultaneous free and select, and draining again.
        expQ.push_back(6'd5);
        expQ.push_back(6'd40);
        expQ.push_back(6'd41);
        expQ.push_back(6'd7);
        expQ.push_back(6'd42);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ack, vecs[i].freeValid, vecs[i].freeTag);
            checkOutput($sformatf("vec%0dValid", i), {63'd0, oAllocValid}, {63'd0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0dTag", i), {58'd0, oAllocTag}, {58'd0, vecs[i].expTag});
            end
            checkOutput($sformatf("vec%0dCount", i), {57'd0, oFreeCount}, {57'd0, vecs[i].expCount});
            checkOutput($sformatf("vec%0dEmpty", i), {63'd0, oEmpty}, {63'd0, vecs[i].expEmpty});
            checkOutput($sformatf("vec%0dDoubleFree", i), {63'd0, oDoubleFree}, 64'd0);
        end
        checkQueueDrained("tableQueue");

        // Return of tag 50 while its bit is already set.
        applyStimulus(1'b0, 1'b1, 6'd50);
        checkOutput("df50Count0", {57'd0, oFreeCount}, 64'd1);
        applyStimulus(1'b0, 1'b1, 6'd50);
        checkOutput("df50Valid", {63'd0, oAllocValid}, 64'd1);
        checkOutput("df50Tag",   {58'd0, oAllocTag},   64'd50);
`ifdef FREE_LIST_CHECK_EN
        checkOutput("df50Pulse", {63'd0, oDoubleFree}, 64'd1);
        checkOutput("df50Count", {57'd0, oFreeCount},  64'd1);
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("df50PulseEnd", {63'd0, oDoubleFree}, 64'd0);
        checkOutput("df50CountEnd", {57'd0, oFreeCount},  64'd1);
        // Return of the staged, unconsumed tag.
        applyStimulus(1'b0, 1'b1, 6'd50);
        checkOutput("dfStagedPulse", {63'd0, oDoubleFree}, 64'd1);
        checkOutput("dfStagedCount", {57'd0, oFreeCount},  64'd1);
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("dfStagedPulseEnd", {63'd0, oDoubleFree}, 64'd0);
`else
        checkOutput("df50Pulse", {63'd0, oDoubleFree}, 64'd0);
        checkOutput("df50Count", {57'd0, oFreeCount},  64'd2);
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("df50PulseEnd", {63'd0, oDoubleFree}, 64'd0);
        checkOutput("df50CountEnd", {57'd0, oFreeCount},  64'd2);
`endif

        // Reset in the middle of allocation with tag 45 staged.
        iRstN = 1'b0;
        #1;
        iRstN = 1'b1;
        for (int t = 32; t < 45; t++) expQ.push_back(6'(t));
        applyStimulus(1'b0, 1'b0, 6'd0);
        for (int k = 0; k < 13; k++) applyStimulus(1'b1, 1'b0, 6'd0);
        checkOutput("midStageTag", {58'd0, oAllocTag}, 64'd45);
        checkQueueDrained("midQueue");
        iAllocAck  = 1'b1;
        iFreeValid = 1'b1;
        iFreeTag   = 6'd3;
        #3 iRstN   = 1'b0;
        #1;
        checkOutput("midResetValid", {63'd0, oAllocValid}, 64'd0);
        checkOutput("midResetTag",   {58'd0, oAllocTag},   64'd0);
        checkOutput("midResetCount", {57'd0, oFreeCount},  64'd32);
        iAllocAck  = 1'b0;
        iFreeValid = 1'b0;
        iFreeTag   = '0;
        @(posedge iClk);
        #1;
        checkOutput("heldResetCount", {57'd0, oFreeCount}, 64'd32);
        iRstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("postResetValid", {63'd0, oAllocValid}, 64'd1);
        checkOutput("postResetTag",   {58'd0, oAllocTag},   64'd32);
        checkOutput("postResetCount", {57'd0, oFreeCount},  64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
